// File: rtl/axis_wb_rx_capture_if.sv
// Bus bundle for the frame capture block: Wishbone slave port plus the AXI-Stream sink.
// The master modport is the bus/stream driver side; the slave modport is the capture block.
interface axis_wb_rx_capture_if #(
  parameter int USER_WIDTH = 1
);
  logic [31:0]           wbs_addr_i;
  logic [31:0]           wbs_data_i;
  logic [31:0]           wbs_data_o;
  logic                  wbs_we_i;
  logic                  wbs_stb_i;
  logic                  wbs_ack_o;
  logic [7:0]            s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;
  logic [USER_WIDTH-1:0] s_axis_tuser;

  modport master (
    output wbs_addr_i, wbs_data_i, wbs_we_i, wbs_stb_i,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  wbs_data_o, wbs_ack_o, s_axis_tready
  );

  modport slave (
    input  wbs_addr_i, wbs_data_i, wbs_we_i, wbs_stb_i,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output wbs_data_o, wbs_ack_o, s_axis_tready
  );
endinterface

// File: rtl/axis_wb_rx_capture.sv
// AXI-Stream frame sink: captures one frame into a byte buffer and hands it to firmware
// over Wishbone (poll STAT, drain DATA, release via CTRL).
module axis_wb_rx_capture #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0200,
  parameter int          BUF_DEPTH  = 256,
  parameter int          DATA_WIDTH = 8,
  parameter int          USER_WIDTH = 1
) (
  input logic                 clk,
  input logic                 rst,
  axis_wb_rx_capture_if.slave bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, RECV, DROP, HOLD} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [LW-1:0]   rdPtr_q, rdPtr_d;
  logic [LW-1:0]   len_q, len_d;
  logic            enable_q, enable_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     fcnt_q, fcnt_d;
  logic [31:0]     dcnt_q, dcnt_d;
  logic            ack_q;
  logic [31:0]     rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] bufMem [BUF_DEPTH];

  logic [7:0]            wbOff;
  logic                  wbHit, wbAccess, wbWrite, wbRead;
  logic                  ctrlWrite, releaseReq, clearOvf, dataRead;
  logic                  tready, beat, bufWe;
  logic [USER_WIDTH-1:0] tuser;
  logic                  unused_wdata;

  assign wbOff      = bus.wbs_addr_i[7:0];
  assign wbHit      = (bus.wbs_addr_i[31:8] == BASE_ADDR[31:8]) && (wbOff <= 8'h10);
  assign wbAccess   = bus.wbs_stb_i && wbHit && !ack_q;
  assign wbWrite    = wbAccess && bus.wbs_we_i;
  assign wbRead     = wbAccess && !bus.wbs_we_i;
  assign ctrlWrite  = wbWrite && (wbOff == 8'h00);
  assign releaseReq = ctrlWrite && bus.wbs_data_i[1];
  assign clearOvf   = ctrlWrite && bus.wbs_data_i[2];
  assign dataRead   = wbRead && (wbOff == 8'h08);
  assign tuser      = bus.s_axis_tuser;
  assign beat       = bus.s_axis_tvalid && tready;
  assign unused_wdata = ^bus.wbs_data_i[31:3];

  assign bus.wbs_ack_o     = ack_q;
  assign bus.wbs_data_o    = rdata_q;
  assign bus.s_axis_tready = tready;

  // With enable dropped and no frame in progress, RECV stops accepting and falls back to IDLE.
  always_comb begin
    tready = 1'b0;
    case (state_q)
      RECV:    tready = enable_q || (wrPtr_q != '0);
      DROP:    tready = 1'b1;
      default: tready = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    len_d    = len_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    fcnt_d   = fcnt_q;
    dcnt_d   = dcnt_q;
    bufWe    = 1'b0;
    enable_d = ctrlWrite ? bus.wbs_data_i[0] : enable_q;
    if (clearOvf) ovf_d = 1'b0;
    if (dataRead && (rdPtr_q < len_q)) rdPtr_d = rdPtr_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (enable_q) begin
          state_d = RECV;
          wrPtr_d = '0;
        end
      end
      RECV: begin
        if (!enable_q && (wrPtr_q == '0)) begin
          state_d = IDLE;
        end else if (beat) begin
          // Enable removed mid-frame: the rest of the frame is thrown away and counted as dropped.
          if (!enable_q) begin
            if (bus.s_axis_tlast) begin
              dcnt_d  = dcnt_q + 32'd1;
              wrPtr_d = '0;
              state_d = IDLE;
            end else begin
              state_d = DROP;
            end
          end else begin
            bufWe = 1'b1;
            if (bus.s_axis_tlast) begin
              if (tuser[0]) begin
                dcnt_d  = dcnt_q + 32'd1;
                wrPtr_d = '0;
              end else begin
                state_d = HOLD;
                len_d   = LW'(wrPtr_q) + 1'b1;
                valid_d = 1'b1;
                fcnt_d  = fcnt_q + 32'd1;
                rdPtr_d = '0;
              end
            end else if (wrPtr_q == PW'(BUF_DEPTH - 1)) begin
              state_d = DROP;
              ovf_d   = 1'b1;
            end else begin
              wrPtr_d = wrPtr_q + 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (beat && bus.s_axis_tlast) begin
          dcnt_d  = dcnt_q + 32'd1;
          wrPtr_d = '0;
          state_d = enable_q ? RECV : IDLE;
        end
      end
      HOLD: begin
        if (releaseReq) begin
          valid_d = 1'b0;
          wrPtr_d = '0;
          state_d = enable_d ? RECV : IDLE;
        end
      end
    endcase
  end

  // Read data is only driven during the ack cycle; it is zero otherwise.
  always_comb begin
    rdata_d = '0;
    if (wbRead) begin
      case (wbOff)
        8'h00: rdata_d = {31'b0, enable_q};
        8'h04: rdata_d = {16'(len_q), 14'b0, ovf_q, valid_q};
        8'h08: if (rdPtr_q < len_q) rdata_d = 32'(bufMem[rdPtr_q[PW-1:0]]);
        8'h0C: rdata_d = fcnt_q;
        8'h10: rdata_d = dcnt_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      len_q    <= '0;
      enable_q <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      fcnt_q   <= '0;
      dcnt_q   <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      len_q    <= len_d;
      enable_q <= enable_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      fcnt_q   <= fcnt_d;
      dcnt_q   <= dcnt_d;
      ack_q    <= wbAccess;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bufWe) bufMem[wrPtr_q] <= bus.s_axis_tdata;
  end
endmodule
